// File: rtl/fifo_pkt_reader.sv
// Drains a registered-read FIFO through a 3-entry skid buffer into a framed
// valid/ready packet stream. Starved packets are padded with zero words after
// a timeout. Optional checksum output: define PKT_CHECKSUM_EN.
module fifo_pkt_reader #(
  parameter int FIFO_WIDTH  = 16,
  parameter int PKT_LEN     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  m_pad,
  output logic [FIFO_WIDTH-1:0] m_csum,
  output logic                  err_underflow
);

  localparam int IDX_W = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    PAD
  } state_t;

  state_t state_q, state_d;

  logic [FIFO_WIDTH-1:0] buf_mem [3];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [1:0]            buf_cnt;
  logic                  inflight;
  logic [IDX_W-1:0]      word_idx;
  logic [TO_W-1:0]       starve_cnt;
  logic                  err_q;

  logic                  buf_vld;
  logic [2:0]            occupancy;
  logic                  hs;
  logic                  push;
  logic                  pop;
  logic                  starve_cond;
  logic                  starve_hit;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read-ahead is bounded by buffered plus in-flight words so the buffer never overflows.
  always_comb begin
    buf_vld    = (buf_cnt != 2'd0);
    occupancy  = {1'b0, buf_cnt} + {2'b00, inflight};
    fifo_rd_en = rst_n && !fifo_empty && (state_q != PAD) && (occupancy < 3'd3);
  end

  always_comb begin
    starve_cond = (state_q == STREAM) && (word_idx != '0) && !buf_vld &&
                  !inflight && fifo_empty;
    starve_hit  = starve_cond && (starve_cnt == TO_LAST);
  end

  always_comb begin
    state_d = state_q;
    m_valid = buf_vld;
    m_pad   = 1'b0;
    m_data  = buf_vld ? buf_mem[rd_ptr] : '0;
    case (state_q)
      IDLE: begin
        if (fifo_rd_en) state_d = STREAM;
      end
      STREAM: begin
        if (starve_hit)
          state_d = PAD;
        else if (!buf_vld && !inflight && (word_idx == '0) && !fifo_rd_en)
          state_d = IDLE;
      end
      PAD: begin
        m_valid = 1'b1;
        m_pad   = 1'b1;
        m_data  = '0;
        if (m_ready && (word_idx == LAST_IDX)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_sop = m_valid && (word_idx == '0);
    m_eop = m_valid && (word_idx == LAST_IDX);
    hs    = m_valid && m_ready;
    push  = inflight;
    pop   = hs && !m_pad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      buf_cnt  <= '0;
      for (int unsigned i = 0; i < 3; i++) buf_mem[i] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (push) begin
        buf_mem[wr_ptr] <= fifo_data_out;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  word_idx <= '0;
    else if (hs) word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           starve_cnt <= '0;
    else if (starve_cond) starve_cnt <= starve_cnt + 1'b1;
    else                  starve_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err_q <= 1'b0;
    else if (fifo_underflow) err_q <= 1'b1;
  end

  assign err_underflow = err_q;

`ifdef PKT_CHECKSUM_EN
  logic [FIFO_WIDTH-1:0] csum_acc;

  // Loading the sop word directly is the clear-then-fold of a fresh packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  csum_acc <= '0;
    else if (hs) csum_acc <= m_sop ? m_data : (csum_acc ^ m_data);
  end

  assign m_csum = m_eop ? (csum_acc ^ m_data) : '0;
`else
  assign m_csum = '0;
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Scoreboard bench for fifo_pkt_reader: a behavioural registered-read FIFO feeds
// the DUT, directed stimulus queues expected words, a negedge monitor checks them.
module tb_fifo_pkt_reader;
  localparam int W  = 16;
  localparam int PL = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_underflow = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_sop, m_eop, m_pad;
  logic [W-1:0] m_csum;
  logic         err_underflow;

  typedef struct packed {
    logic [W-1:0] d;
    logic         sop;
    logic         eop;
    logic         pad;
    logic [W-1:0] cs;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] fq[$];
  logic [W-1:0] pend[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, rd_pulses = 0, hs_cnt = 0, viol = 0;
  int first_rd = -1, first_valid = -1, first_pad = -1, last_hs = -1;
  int lcyc;

  fifo_pkt_reader #(.FIFO_WIDTH(W), .PKT_LEN(PL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop), .m_pad(m_pad),
    .m_csum(m_csum), .err_underflow(err_underflow)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO: one-cycle registered read, shares the reader's reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_data_out <= '0;
      fifo_empty    <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_data_out <= fq.pop_front();
      while (pend.size() > 0) fq.push_back(pend.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_pulses++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (fifo_rd_en && fifo_empty) viol++;
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (m_valid && m_pad && first_pad < 0) first_pad = cyc;
    if (rst_n && m_valid && m_ready) begin
      hs_cnt++;
      last_hs = cyc;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got data=0x%0h sop=%b eop=%b pad=%b, required no word",
                 m_data, m_sop, m_eop, m_pad);
      end else begin
        mon_e = sb.pop_front();
        check("stream_word{data,sop,eop,pad,csum}", {m_data, m_sop, m_eop, m_pad, m_csum}, mon_e);
      end
    end
  end

  function automatic logic [W-1:0] cs(input logic [W-1:0] v);
`ifdef PKT_CHECKSUM_EN
    return v;
`else
    return '0;
`endif
  endfunction

  function automatic exp_t mk(input logic [W-1:0] d, input logic sop, input logic eop,
                              input logic pad, input logic [W-1:0] c);
    exp_t e;
    e.d = d; e.sop = sop; e.eop = eop; e.pad = pad; e.cs = c;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_marks();
    rd_pulses = 0; hs_cnt = 0;
    first_rd = -1; first_valid = -1; first_pad = -1; last_hs = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    check("reset_outputs", {fifo_rd_en, m_valid, m_sop, m_eop, m_pad, err_underflow, m_data, m_csum}, '0);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int k = 0;
    while (sb.size() != 0 && k < maxc) begin
      tick(1);
      k++;
    end
    check(name, sb.size(), 0);
    tick(2);
  endtask

  task automatic wait_hs(input string name, input int n, input int maxc);
    int k = 0;
    while (hs_cnt < n && k < maxc) begin
      tick(1);
      k++;
    end
    check(name, hs_cnt >= n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(1);
    do_reset();

    // Two back-to-back packets at full rate.
    clear_marks();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++)
      sb.push_back(mk(16'(i), (i % 4) == 1, (i % 4) == 0, 1'b0,
                      (i == 4) ? cs(16'h0004) : (i == 8) ? cs(16'h000C) : 16'h0000));
    for (int i = 1; i <= 8; i++) pend.push_back(16'(i));
    wait_drain("t1_drain", 60);
    check("t1_latency", first_valid - first_rd, 2);
    check("t1_no_bubbles", last_hs - first_valid, 7);
    check("t1_idle_after", {m_valid, fifo_rd_en}, 2'b00);

    // Backpressure: read-ahead limited to three words.
    do_reset();
    clear_marks();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) pend.push_back(16'(i));
    tick(12);
    check("t2_rd_pulses", rd_pulses, 3);
    check("t2_head_held", {m_valid, m_sop, m_data}, {1'b1, 1'b1, 16'h0001});
    tick(3);
    check("t2_head_stable", {m_valid, m_data, rd_pulses[7:0]}, {1'b1, 16'h0001, 8'd3});
    for (int i = 1; i <= 8; i++)
      sb.push_back(mk(16'(i), (i % 4) == 1, (i % 4) == 0, 1'b0,
                      (i == 4) ? cs(16'h0004) : (i == 8) ? cs(16'h000C) : 16'h0000));
    m_ready = 1'b1;
    wait_drain("t2_drain", 60);
    check("t2_word_count", hs_cnt, 8);

    // Starvation mid-packet: two pads close the packet.
    do_reset();
    clear_marks();
    sb.push_back(mk(16'h00A1, 1'b1, 1'b0, 1'b0, 16'h0000));
    sb.push_back(mk(16'h00A2, 1'b0, 1'b0, 1'b0, 16'h0000));
    sb.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000));
    sb.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b1, cs(16'h0003)));
    pend.push_back(16'h00A1);
    pend.push_back(16'h00A2);
    wait_hs("t3_real_words", 2, 20);
    lcyc = last_hs;
    wait_drain("t3_drain", 60);
    check("t3_pad_start", first_pad - lcyc, TO + 1);
    for (int i = 1; i <= 4; i++)
      sb.push_back(mk(16'h00B0 + 16'(i), i == 1, i == 4, 1'b0, (i == 4) ? cs(16'h0004) : 16'h0000));
    for (int i = 1; i <= 4; i++) pend.push_back(16'h00B0 + 16'(i));
    wait_drain("t3_after_pad", 40);

    // Data returns in the cycle the counter would expire: no padding.
    do_reset();
    clear_marks();
    for (int i = 1; i <= 4; i++)
      sb.push_back(mk(16'h00C0 + 16'(i), i == 1, i == 4, 1'b0, (i == 4) ? cs(16'h0004) : 16'h0000));
    pend.push_back(16'h00C1);
    pend.push_back(16'h00C2);
    wait_hs("t4_real_words", 2, 20);
    lcyc = last_hs;
    for (int k = 0; k < 40 && cyc < lcyc + TO - 1; k++) tick(1);
    pend.push_back(16'h00C3);
    pend.push_back(16'h00C4);
    wait_drain("t4_drain", 40);
    check("t4_no_pad", first_pad, -1);

    // Sticky underflow error.
    check("t5_err_clear", err_underflow, 1'b0);
    fifo_underflow = 1'b1;
    tick(1);
    fifo_underflow = 1'b0;
    check("t5_err_set", err_underflow, 1'b1);
    tick(5);
    check("t5_err_sticky", err_underflow, 1'b1);
    do_reset();

    // Checksum packet.
    clear_marks();
    m_ready = 1'b1;
    sb.push_back(mk(16'h00F0, 1'b1, 1'b0, 1'b0, 16'h0000));
    sb.push_back(mk(16'h0F00, 1'b0, 1'b0, 1'b0, 16'h0000));
    sb.push_back(mk(16'h000F, 1'b0, 1'b0, 1'b0, 16'h0000));
    sb.push_back(mk(16'hF000, 1'b0, 1'b1, 1'b0, cs(16'hFFFF)));
    pend.push_back(16'h00F0);
    pend.push_back(16'h0F00);
    pend.push_back(16'h000F);
    pend.push_back(16'hF000);
    wait_drain("t6_drain", 40);

    // Reset mid-packet drops buffered words; next word starts a packet.
    clear_marks();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) pend.push_back(16'h00D0 + 16'(i));
    sb.push_back(mk(16'h00D1, 1'b1, 1'b0, 1'b0, 16'h0000));
    tick(8);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    check("t7_one_word", hs_cnt, 1);
    do_reset();
    clear_marks();
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++)
      sb.push_back(mk(16'h00E0 + 16'(i), i == 1, i == 4, 1'b0, (i == 4) ? cs(16'h0004) : 16'h0000));
    for (int i = 1; i <= 4; i++) pend.push_back(16'h00E0 + 16'(i));
    wait_drain("t7_drain", 40);
    check("t7_word_count", hs_cnt, 4);

    check("rd_en_while_empty", viol, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Downstream drain stage for the project's synchronous FIFO. It pops words through the FIFO read port, absorbs the FIFO's one-cycle registered read latency in a 3-entry skid buffer, and presents a valid/ready stream framed into fixed-length packets with start-of-packet and end-of-packet markers. If a packet stalls mid-way because the FIFO runs dry, it pads the packet out with zero words after a timeout.

## Interface
- FIFO_WIDTH, 16, data word width; must equal the FIFO's width.
- PKT_LEN, 4, words per packet; legal range 2..256.
- TIMEOUT_CYC, 16, mid-packet starvation cycles before padding; legal range 1..1023.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fifo_rd_en  out  1  FIFO read request, same meaning as the FIFO's rd_en.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_underflow  in  1  FIFO underflow flag.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  FIFO_WIDTH  output word.
- m_sop  out  1  first word of packet; qualified by m_valid.
- m_eop  out  1  last word of packet; qualified by m_valid.
- m_pad  out  1  word is padding (m_data = 0).
- m_csum  out  FIFO_WIDTH  packet checksum; meaningful with m_eop (see Configuration).
- err_underflow  out  1  sticky error; set when fifo_underflow is seen high.

## Operation
Skid buffer and reads:
- Skid buffer: 3-entry FIFO with count buf_cnt (0..3).
- inflight: fifo_rd_en registered by one cycle.
- fifo_rd_en = rst_n && !fifo_empty && state != PAD && (buf_cnt + inflight) < 3.
  - This is combinational from registered state and fifo_empty only; there is no path from m_ready.
  - fifo_rd_en is never asserted while fifo_empty = 1.
- When inflight = 1, fifo_data_out is written into the buffer at that edge.
- A handshake is m_valid && m_ready. It pops the buffer head.
  - A push and a pop in the same cycle leave buf_cnt unchanged.
- While m_valid = 1 and m_ready = 0, m_data, m_sop, m_eop and m_pad hold stable.

Framing:
- word_idx runs 0..PKT_LEN-1 and advances on each handshake, wrapping to 0 after PKT_LEN-1.
- m_sop = m_valid && word_idx == 0.
- m_eop = m_valid && word_idx == PKT_LEN-1.

State machine (states IDLE, STREAM, PAD; reset state IDLE):
- IDLE → STREAM when fifo_rd_en = 1.
- STREAM → IDLE when buf_cnt = 0, inflight = 0, word_idx = 0 and fifo_rd_en = 0.
- STREAM → PAD when the starvation counter reaches TIMEOUT_CYC.
  - The starvation counter increments each cycle in STREAM while word_idx != 0, buf_cnt = 0, inflight = 0 and fifo_empty = 1.
  - It clears whenever any of those conditions is false.
- PAD behaviour:
  - Drives m_valid = 1, m_data = 0, m_pad = 1; fifo_rd_en = 0.
  - word_idx advances on each handshake.
  - Goes to IDLE on the m_eop handshake.
  - Padding never begins a packet and never re-orders data.

err_underflow: set when fifo_underflow = 1; cleared only by reset.

## Timing
- Reset values: fifo_rd_en 0, m_valid 0, m_data 0, m_sop 0, m_eop 0, m_pad 0, m_csum 0, err_underflow 0. Internal state: word_idx 0, buf_cnt 0, inflight 0, starvation counter 0, state IDLE.
- Asserting rst_n low mid-packet drops all buffered data and the partial packet immediately.
  - The first post-reset word carries m_sop.
- Latency: fifo_rd_en in cycle N → data in buffer at the edge ending cycle N+1 → m_valid = 1 in cycle N+2 (if the buffer was empty).
- Throughput: with m_ready held at 1 and the FIFO non-empty, one word per cycle is sustained.
- With m_ready held at 0:
  - at most 3 words are read ahead;
  - fifo_rd_en drops once buf_cnt + inflight = 3.
- Padding starts TIMEOUT_CYC + 1 cycles after the last real word drains during starvation. The first pad word is valid in the cycle after entry to PAD.
- If fifo_empty falls in the same cycle the counter would hit TIMEOUT_CYC, the counter clears and no padding occurs.

## Configuration
- PKT_CHECKSUM_EN defined:
  - A running XOR accumulator clears on the sop handshake and folds in each handshaked word.
  - m_csum = accumulator XOR m_data while m_eop = 1; otherwise 0.
  - Pad words contribute 0.
- PKT_CHECKSUM_EN undefined: the port is kept and m_csum is tied to 0; no accumulator logic.

## Test plan
- Reset, then 8 words 0x0001..0x0008 pushed, m_ready = 1, PKT_LEN = 4:
  - two packets; m_sop on 0x0001 and 0x0005; m_eop on 0x0004 and 0x0008;
  - first m_valid exactly 2 cycles after the first fifo_rd_en; no bubbles.
- FIFO full, m_ready = 0 for 10 cycles:
  - exactly 3 fifo_rd_en pulses; m_data stays 0x0001;
  - on release, 8 words delivered in order with no loss or duplication.
- 2 words pushed, then FIFO kept empty, TIMEOUT_CYC = 16:
  - after 17 starvation cycles, two pad words are emitted (m_data = 0, m_pad = 1); the second carries m_eop;
  - state returns to IDLE; fifo_rd_en is never high while fifo_empty = 1.
- Word arrives in the cycle the starvation counter would reach 15:
  - no padding; the packet completes with real data.
- fifo_underflow forced high for 1 cycle:
  - err_underflow = 1 and stays set until rst_n is pulsed low.
- With PKT_CHECKSUM_EN, packet 0x00F0, 0x0F00, 0x000F, 0xF000:
  - m_csum = 0xFFFF on the m_eop word.
  - Without the macro, m_csum = 0 throughout.
  - rst_n low mid-packet: the next packet's m_sop is on the first post-reset word.
